pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_TIMEOUT, default 40, giving the maximum cycles spent in DIV_WAIT before a forced abort.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the stall-cycle performance counter.
REQ-003 The block SHALL have input clk, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have input rst, 1 bit, reset: synchronous, active-high.
REQ-005 The block SHALL have input id_stallreq, 1 bit: ID load-use hazard detected this cycle.
REQ-006 The block SHALL have input ex_div_start, 1 bit: one-cycle pulse while a DIV/DIVU occupies EX.
REQ-007 The block SHALL have input div_ready, 1 bit: one-cycle pulse, divider result valid this cycle.
REQ-008 The block SHALL have input ext_stall, 1 bit: memory/SRAM wait request, whole pipeline frozen.
REQ-009 The block SHALL have output stall, 6 bits, the StallBus; bit0=PC, bit1=IF/ID, bit2=ID/EX, bit3=EX/MEM, bit4=MEM/WB, bit5=WB; 1=Stop.
REQ-010 The block SHALL have output div_busy, 1 bit, high while the FSM is in DIV_WAIT.
REQ-011 The block SHALL have output div_timeout, 1 bit, a sticky abort flag.
REQ-012 The block SHALL have output stall_cycles, CNT_W bits, a saturating count of cycles with stall[0]=1.

Function
REQ-013 The FSM SHALL have two states: IDLE and DIV_WAIT.
REQ-014 IDLE SHALL go to DIV_WAIT when ex_div_start=1; in that case the internal wait counter SHALL load 0.
REQ-015 DIV_WAIT SHALL go to IDLE when div_ready=1.
REQ-016 DIV_WAIT SHALL also go to IDLE, setting div_timeout=1, when the wait counter equals DIV_TIMEOUT-1 and div_ready=0.
REQ-017 The wait counter SHALL increment by 1 every cycle in DIV_WAIT, including cycles with ext_stall=1.
REQ-018 In IDLE, div_ready SHALL be ignored, including when it coincides with ex_div_start.
REQ-019 In DIV_WAIT, ex_div_start SHALL be ignored.
REQ-020 div_stall SHALL be (IDLE & ex_div_start) | (DIV_WAIT & ~div_ready & ~timeout_hit), where timeout_hit is the REQ-016 condition; this is combinational with zero latency.
REQ-021 stall SHALL be combinational, with priority in this order:
  - ext_stall -> 6'b111111
  - else div_stall -> 6'b001111
  - else id_stallreq -> 6'b000111 (bubble inserted into ID/EX)
  - else 6'b000000
REQ-022 When div_stall and id_stallreq are both active, the 6'b001111 pattern SHALL win and no bubble SHALL be inserted.
REQ-023 stall_cycles SHALL increment by 1 on each edge where stall[0]=1 and SHALL hold at all-ones (no wrap).
REQ-024 div_timeout SHALL stay at 1 until reset.
REQ-025 Once set, div_timeout SHALL NOT change stall behaviour for later divides.

Reset
REQ-026 While rst=1 the block SHALL enter state IDLE, clear the wait counter, and set div_timeout=0 and stall_cycles=0.
REQ-027 While rst=1, stall SHALL be 6'b000000 and div_busy SHALL be 0, regardless of the other inputs.
REQ-028 A reset during DIV_WAIT SHALL abort the divide wait with no timeout flag set.

Verification
REQ-029 Load-use: assert id_stallreq for 1 cycle in IDLE -> stall=000111 that cycle, then 000000; stall_cycles=1.
REQ-030 Divide: pulse ex_div_start, then div_ready 5 cycles later -> stall=001111 for 5 cycles, 000000 on the div_ready cycle; div_busy high for 5 cycles; stall_cycles=5.
REQ-031 Priority: during DIV_WAIT assert id_stallreq and then ext_stall -> stall=001111 under id_stallreq alone, stall=111111 under ext_stall; the wait counter keeps advancing throughout.
REQ-032 Timeout: pulse ex_div_start and never assert div_ready -> stall=001111 for 40 cycles, then IDLE with div_timeout=1 sticky.
REQ-033 Corner: in IDLE pulse ex_div_start and div_ready together -> the block enters DIV_WAIT and stall=001111.
REQ-034 Corner: assert rst mid-DIV_WAIT -> the next cycle shows IDLE, stall=000000, div_timeout=0, stall_cycles=0.
REQ-035 Saturation: with CNT_W=4 and stall held for 20 cycles -> stall_cycles stays at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the hazard/divider sources and the stall controller.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             id_stallreq;
  logic             ex_div_start;
  logic             div_ready;
  logic             ext_stall;
  logic [5:0]       stall;
  logic             div_busy;
  logic             div_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_stallreq, ex_div_start, div_ready, ext_stall,
    input  stall, div_busy, div_timeout, stall_cycles
  );

  modport slave (
    input  id_stallreq, ex_div_start, div_ready, ext_stall,
    output stall, div_busy, div_timeout, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges external wait, divider wait and load-use
// hazards into the 6-bit StallBus, tracks the divider with a timeout guard and
// counts stalled cycles with a saturating counter.
module pipe_stall_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  localparam logic [5:0] STALL_ALL  = 6'b111111;
  localparam logic [5:0] STALL_DIV  = 6'b001111;
  localparam logic [5:0] STALL_LOAD = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic {
    IDLE     = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_hit;
  logic               div_stall;
  logic               div_timeout_q;
  logic [CNT_W-1:0]   stall_cnt;
  logic [5:0]         stall_bus;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_ONE);
  endfunction

  // Divider gave no answer within the allowed window.
  assign timeout_hit = (state == DIV_WAIT) && (wait_cnt == WAIT_LAST) && !bus.div_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state and divider stall request; the start cycle itself stalls.
  always_comb begin
    state_nxt = state;
    div_stall = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ex_div_start) begin
          state_nxt = DIV_WAIT;
          div_stall = 1'b1;
        end
      end
      DIV_WAIT: begin
        if (bus.div_ready || timeout_hit) state_nxt = IDLE;
        else                              div_stall = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter keeps running while frozen by ext_stall so a hung divider
  // still times out.
  always_ff @(posedge clk) begin
    if (rst)                                    wait_cnt <= '0;
    else if (state == IDLE && bus.ex_div_start) wait_cnt <= '0;
    else if (state == DIV_WAIT)                 wait_cnt <= wait_cnt + WAIT_ONE;
  end

  // Sticky abort flag, cleared only by reset; it does not feed back into stalling.
  always_ff @(posedge clk) begin
    if (rst)              div_timeout_q <= 1'b0;
    else if (timeout_hit) div_timeout_q <= 1'b1;
  end

  // StallBus priority: external freeze, then divider, then load-use bubble.
  always_comb begin
    stall_bus = STALL_NONE;
    if (!rst) begin
      if (bus.ext_stall)     stall_bus = STALL_ALL;
      else if (div_stall)    stall_bus = STALL_DIV;
      else if (bus.id_stallreq) stall_bus = STALL_LOAD;
    end
  end

  // Performance counter of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst)               stall_cnt <= '0;
    else if (stall_bus[0]) stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.stall        = stall_bus;
  assign bus.div_busy     = (state == DIV_WAIT) && !rst;
  assign bus.div_timeout  = div_timeout_q;
  assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed per-cycle vectors push their
// hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_stall_ctrl;

  localparam int CNT_W       = 4;
  localparam int DIV_TIMEOUT = 40;
  localparam int CNT_MAX     = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(
    .DIV_TIMEOUT (DIV_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic       busy;
    logic       tmo;
    int         cnt;
    bit         full;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  // One clock cycle of stimulus with its expected outputs for that cycle.
  task automatic cyc(input string nm, input bit r, input bit id, input bit ds,
                     input bit dr, input bit es, input logic [5:0] xs,
                     input bit xb, input bit xt, input bit full = 1'b1);
    exp_t e;
    #1;
    rst              = r;
    bus.id_stallreq  = id;
    bus.ex_div_start = ds;
    bus.div_ready    = dr;
    bus.ext_stall    = es;
    e.name  = nm;
    e.stall = xs;
    e.busy  = xb;
    e.tmo   = xt;
    e.cnt   = exp_cnt;
    e.full  = full;
    expq.push_back(e);
    @(posedge clk);
    if (r)                               exp_cnt = 0;
    else if (xs[0] && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (bus.stall !== e.stall) begin
        failures++;
        $display("FAIL %s stall act=%b exp=%b t=%0t", e.name, bus.stall, e.stall, $time);
      end
      checks++;
      if (bus.div_busy !== e.busy) begin
        failures++;
        $display("FAIL %s div_busy act=%b exp=%b t=%0t", e.name, bus.div_busy, e.busy, $time);
      end
      if (e.full) begin
        checks++;
        if (bus.div_timeout !== e.tmo) begin
          failures++;
          $display("FAIL %s div_timeout act=%b exp=%b t=%0t", e.name, bus.div_timeout, e.tmo, $time);
        end
        checks++;
        if (bus.stall_cycles !== CNT_W'(e.cnt)) begin
          failures++;
          $display("FAIL %s stall_cycles act=%0d exp=%0d t=%0t", e.name, bus.stall_cycles, e.cnt, $time);
        end
      end
    end
  end

  initial begin
    rst              = 1'b1;
    bus.id_stallreq  = 1'b0;
    bus.ex_div_start = 1'b0;
    bus.div_ready    = 1'b0;
    bus.ext_stall    = 1'b0;
    @(posedge clk);

    // Reset with every request asserted: outputs quiet.
    cyc("rst_in0", 1, 1, 1, 1, 1, 6'b000000, 0, 0, 0);
    cyc("rst_in1", 1, 1, 1, 1, 1, 6'b000000, 0, 0);
    cyc("idle0",   0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Load-use bubble.
    cyc("lu_hit",  0, 1, 0, 0, 0, 6'b000111, 0, 0);
    cyc("lu_done", 0, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc("lu_cnt",  0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Divide answered 5 cycles after start.
    cyc("div_rst",   1, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc("div_start", 0, 0, 1, 0, 0, 6'b001111, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc("div_wait", 0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cyc("div_ready", 0, 0, 0, 1, 0, 6'b000000, 1, 0);
    cyc("div_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Priority inside DIV_WAIT, then left to time out.
    cyc("pri_rst",   1, 0, 0, 0, 0, 6'b000000, 0, 0);
    cyc("pri_start", 0, 0, 1, 0, 0, 6'b001111, 0, 0);
    cyc("pri_id",    0, 1, 0, 0, 0, 6'b001111, 1, 0);
    cyc("pri_ext",   0, 0, 0, 0, 1, 6'b111111, 1, 0);
    cyc("pri_both",  0, 1, 0, 0, 1, 6'b111111, 1, 0);
    for (int i = 3; i < DIV_TIMEOUT - 1; i++)
      cyc("to_wait", 0, 0, (i == 10), 0, 0, 6'b001111, 1, 0);
    cyc("to_abort", 0, 0, 0, 0, 0, 6'b000000, 1, 0);
    cyc("to_idle",  0, 0, 0, 0, 0, 6'b000000, 0, 1);
    cyc("to_stick", 0, 0, 0, 0, 0, 6'b000000, 0, 1);

    // Later divide behaves normally with the sticky flag set.
    cyc("d2_start", 0, 0, 1, 0, 0, 6'b001111, 0, 1);
    cyc("d2_wait",  0, 0, 0, 0, 0, 6'b001111, 1, 1);
    cyc("d2_ready", 0, 0, 0, 1, 0, 6'b000000, 1, 1);
    cyc("d2_after", 0, 0, 0, 0, 0, 6'b000000, 0, 1);

    // Reset in the middle of DIV_WAIT.
    cyc("rw_start", 0, 0, 1, 0, 0, 6'b001111, 0, 1);
    cyc("rw_wait",  0, 0, 0, 0, 0, 6'b001111, 1, 1);
    cyc("rw_rst",   1, 1, 0, 0, 0, 6'b000000, 0, 1);
    cyc("rw_idle",  0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Start and ready together in IDLE: ready ignored.
    cyc("sr_both",  0, 0, 1, 1, 0, 6'b001111, 0, 0);
    cyc("sr_wait",  0, 0, 0, 0, 0, 6'b001111, 1, 0);
    cyc("sr_ready", 0, 0, 0, 1, 0, 6'b000000, 1, 0);
    cyc("sr_idle",  0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Stray div_ready in IDLE does nothing.
    cyc("rd_idle",  0, 0, 0, 1, 0, 6'b000000, 0, 0);
    cyc("rd_after", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    // Counter saturation with a long external freeze.
    cyc("sat_rst", 1, 0, 0, 0, 0, 6'b000000, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc("sat_ext", 0, 0, 0, 0, 1, 6'b111111, 0, 0);
    cyc("sat_hold", 0, 0, 0, 0, 0, 6'b000000, 0, 0);

    repeat (2) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain pending act=%0d exp=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
